// File: rtl/add2_round_arbiter.sv
// Round-robin arbiter sharing one (in1+in2)/2 round-toward-zero datapath
// across NUM_REQ streaming requesters, with optional lock until tlast.
module add2_round_arbiter #(
  parameter int WIDTH        = 16,
  parameter int NUM_REQ      = 4,
  parameter int SRC_W        = 2,
  parameter int LOCK_ON_LAST = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ*2*WIDTH-1:0] i_tdata,
  input  logic [NUM_REQ-1:0]         i_tlast,
  input  logic [NUM_REQ-1:0]         i_tvalid,
  output logic [NUM_REQ-1:0]         i_tready,
  output logic [WIDTH-1:0]           o_tdata,
  output logic                       o_tlast,
  output logic [SRC_W-1:0]           o_tuser,
  output logic                       o_tvalid,
  input  logic                       o_tready
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [SRC_W-1:0]   lock_idx_reg, lock_idx_next;
  logic [SRC_W-1:0]   ptr_reg, ptr_next;

  logic [WIDTH-1:0]   o_tdata_reg;
  logic               o_tlast_reg;
  logic [SRC_W-1:0]   o_tuser_reg;
  logic               o_tvalid_reg;

  logic               load;
  logic [NUM_REQ-1:0] req_hi;
  logic [NUM_REQ-1:0] req_lo;
  logic               rr_found;
  logic [SRC_W-1:0]   rr_idx;
  logic               grant_any;
  logic [SRC_W-1:0]   grant_idx;
  logic               acc;
  logic               acc_last;
  logic [SRC_W-1:0]   ptr_adv;

  logic [WIDTH-1:0]   op_a [NUM_REQ];
  logic [WIDTH-1:0]   op_b [NUM_REQ];
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   result;

  assign load = !o_tvalid_reg | o_tready;

  // Split requesters into those at/above the pointer and those below it, so
  // the wrap-around search becomes two lowest-index priority encodes.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign op_a[gi]   = i_tdata[gi*2*WIDTH +: WIDTH];
      assign op_b[gi]   = i_tdata[gi*2*WIDTH+WIDTH +: WIDTH];
      assign req_hi[gi] = i_tvalid[gi] & (SRC_W'(gi) >= ptr_reg);
      assign req_lo[gi] = i_tvalid[gi] & (SRC_W'(gi) <  ptr_reg);
      assign i_tready[gi] = reset_n & load & grant_any & (grant_idx == SRC_W'(gi));
    end
  endgenerate

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_lo[j]) begin
        rr_found = 1'b1;
        rr_idx   = SRC_W'(j);
      end
    end
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_hi[j]) begin
        rr_found = 1'b1;
        rr_idx   = SRC_W'(j);
      end
    end
  end

  // A lock grants its owner even while it is idle, stalling everyone else.
  always_comb begin
    grant_any = rr_found;
    grant_idx = rr_idx;
    if (state_reg == LOCKED) begin
      grant_any = 1'b1;
      grant_idx = lock_idx_reg;
    end
  end

  assign acc      = |(i_tvalid & i_tready);
  assign acc_last = i_tlast[grant_idx];
  assign ptr_adv  = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);

  assign sel_a  = op_a[grant_idx];
  assign sel_b  = op_b[grant_idx];
  assign sum    = {sel_a[WIDTH-1], sel_a} + {sel_b[WIDTH-1], sel_b};
  // Arithmetic shift floors; add one back for negative odd sums to truncate toward zero.
  assign result = sum[WIDTH:1] + {{(WIDTH-1){1'b0}}, sum[WIDTH] & sum[0]};

  always_comb begin
    state_next    = state_reg;
    lock_idx_next = lock_idx_reg;
    ptr_next      = ptr_reg;
    if (acc) begin
      case (state_reg)
        IDLE: begin
          ptr_next = ptr_adv;
          if ((LOCK_ON_LAST != 0) && !acc_last) begin
            state_next    = LOCKED;
            lock_idx_next = grant_idx;
          end
        end
        LOCKED: begin
          if (acc_last) begin
            state_next = IDLE;
            ptr_next   = ptr_adv;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      lock_idx_reg <= '0;
      ptr_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      lock_idx_reg <= lock_idx_next;
      ptr_reg      <= ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_tvalid_reg <= 1'b0;
      o_tdata_reg  <= '0;
      o_tlast_reg  <= 1'b0;
      o_tuser_reg  <= '0;
    end else if (load) begin
      o_tvalid_reg <= acc;
      if (acc) begin
        o_tdata_reg <= result;
        o_tlast_reg <= acc_last;
        o_tuser_reg <= grant_idx;
      end
    end
  end

  assign o_tdata  = o_tdata_reg;
  assign o_tlast  = o_tlast_reg;
  assign o_tuser  = o_tuser_reg;
  assign o_tvalid = o_tvalid_reg;

endmodule

// File: tb/tb_add2_round_arbiter.sv
// Directed bench for add2_round_arbiter: a one-deep scoreboard of expected
// output beats is filled on each expected handshake and checked at the output.
module tb_add2_round_arbiter;
  localparam int WIDTH   = 16;
  localparam int NUM_REQ = 4;
  localparam int SRC_W   = 2;

  localparam logic [WIDTH-1:0] RA [7] = '{16'h0001, 16'hFFFF, 16'h0003, 16'hFFFD,
                                          16'h7FFF, 16'h8000, 16'h8000};
  localparam logic [WIDTH-1:0] RB [7] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                          16'h7FFF, 16'h8000, 16'h7FFF};

  logic                       clk = 1'b0;
  logic                       reset_n;
  logic [NUM_REQ*2*WIDTH-1:0] i_tdata;
  logic [NUM_REQ-1:0]         i_tlast;
  logic [NUM_REQ-1:0]         i_tvalid;
  logic [NUM_REQ-1:0]         i_tready;
  logic [WIDTH-1:0]           o_tdata;
  logic                       o_tlast;
  logic [SRC_W-1:0]           o_tuser;
  logic                       o_tvalid;
  logic                       o_tready;

  always #5 clk = ~clk;

  add2_round_arbiter #(
    .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .SRC_W(SRC_W), .LOCK_ON_LAST(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tuser(o_tuser), .o_tvalid(o_tvalid),
    .o_tready(o_tready)
  );

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             l;
    logic [SRC_W-1:0] u;
  } beat_t;

  beat_t sb_q[$];
  logic  exp_ovalid;
  int    checks = 0;
  int    errors = 0;

  function automatic logic [WIDTH-1:0] avg(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    return WIDTH'(s / 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic last, input logic valid);
    i_tdata[k*2*WIDTH +: WIDTH]       = a;
    i_tdata[k*2*WIDTH+WIDTH +: WIDTH] = b;
    i_tlast[k]  = last;
    i_tvalid[k] = valid;
  endtask

  // Called right after a falling edge with inputs already driven; exp_g is the
  // requester expected to hold the grant this cycle (-1 = none).
  task automatic cyc(input int exp_g);
    logic                load;
    logic                xfer;
    logic [NUM_REQ-1:0]  exp_rdy;
    beat_t               b;
    #2;
    load    = !exp_ovalid || o_tready;
    exp_rdy = '0;
    if (exp_g >= 0 && load) exp_rdy[exp_g] = 1'b1;
    chk("o_tvalid", 32'(o_tvalid), 32'(exp_ovalid));
    chk("i_tready", 32'(i_tready), 32'(exp_rdy));
    if (o_tvalid && sb_q.size() > 0) begin
      b = sb_q[0];
      chk("o_tdata", 32'(o_tdata), 32'(b.d));
      chk("o_tlast", 32'(o_tlast), 32'(b.l));
      chk("o_tuser", 32'(o_tuser), 32'(b.u));
      if (o_tready) begin
        void'(sb_q.pop_front());
        $display("beat src=%0d data=%h last=%0b", o_tuser, o_tdata, o_tlast);
      end
    end
    xfer = load && (exp_g >= 0) && i_tvalid[exp_g];
    if (xfer) begin
      b.d = avg(i_tdata[exp_g*2*WIDTH +: WIDTH], i_tdata[exp_g*2*WIDTH+WIDTH +: WIDTH]);
      b.l = i_tlast[exp_g];
      b.u = SRC_W'(exp_g);
      sb_q.push_back(b);
    end
    if (load) exp_ovalid = xfer;
    @(negedge clk);
  endtask

  task automatic drop_all();
    i_tvalid = '0;
    i_tlast  = '0;
  endtask

  initial begin
    reset_n    = 1'b0;
    o_tready   = 1'b1;
    i_tdata    = '0;
    i_tlast    = '0;
    i_tvalid   = '1;
    exp_ovalid = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_i_tready", 32'(i_tready), 32'd0);
    chk("rst_o_tvalid", 32'(o_tvalid), 32'd0);
    chk("rst_o_tdata",  32'(o_tdata),  32'd0);
    chk("rst_o_tlast",  32'(o_tlast),  32'd0);
    chk("rst_o_tuser",  32'(o_tuser),  32'd0);
    @(negedge clk);
    reset_n  = 1'b1;
    i_tvalid = '0;

    // Rounding corners from requester 0, one beat per cycle
    for (int i = 0; i < 7; i++) begin
      set_req(0, RA[i], RB[i], 1'b1, 1'b1);
      cyc(0);
    end
    drop_all();
    cyc(-1);

    // Round-robin with all requesters valid; pointer starts at 1
    for (int k = 0; k < NUM_REQ; k++)
      set_req(k, WIDTH'(k * 100 + 7), WIDTH'(-(k * 3)), 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) cyc((1 + i) % NUM_REQ);
    drop_all();
    cyc(-1);

    // Packet lock on requester 2 with a two-cycle gap mid-packet
    set_req(1, 16'h0010, 16'h0020, 1'b1, 1'b1);
    cyc(1);
    set_req(0, 16'h0100, 16'h0003, 1'b1, 1'b1);
    set_req(2, 16'h1234, 16'h0F00, 1'b0, 1'b1);
    cyc(2);
    set_req(2, 16'hF000, 16'hFFFF, 1'b0, 1'b1);
    cyc(2);
    set_req(2, 16'h0000, 16'h0000, 1'b0, 1'b0);
    cyc(2);
    cyc(2);
    set_req(2, 16'h7000, 16'h0001, 1'b1, 1'b1);
    cyc(2);
    set_req(2, 16'h0000, 16'h0000, 1'b0, 1'b0);
    cyc(0);
    cyc(1);
    drop_all();
    cyc(-1);

    // Backpressure: hold a beat for five cycles, then drain and refill together
    set_req(2, 16'h0AAA, 16'h0555, 1'b1, 1'b1);
    set_req(3, 16'hFFF1, 16'h0004, 1'b1, 1'b1);
    cyc(2);
    o_tready = 1'b0;
    repeat (5) cyc(3);
    o_tready = 1'b1;
    cyc(3);
    drop_all();
    cyc(-1);

    // Idle: the pointer must survive ten empty cycles
    set_req(1, 16'h0042, 16'h0001, 1'b1, 1'b1);
    cyc(1);
    drop_all();
    repeat (10) cyc(-1);
    for (int k = 0; k < NUM_REQ; k++)
      set_req(k, WIDTH'(k + 1), WIDTH'(k * 2), 1'b1, 1'b1);
    cyc(2);
    drop_all();
    cyc(-1);

    // Reset while locked on requester 1 with a beat held at the output
    set_req(1, 16'h0300, 16'h0100, 1'b0, 1'b1);
    cyc(1);
    reset_n = 1'b0;
    set_req(0, 16'h0009, 16'h0007, 1'b1, 1'b1);
    set_req(3, 16'hFF00, 16'h0010, 1'b1, 1'b1);
    #2;
    chk("rst2_i_tready_low", 32'(i_tready), 32'd0);
    @(negedge clk);
    #2;
    chk("rst2_o_tvalid", 32'(o_tvalid), 32'd0);
    chk("rst2_o_tdata",  32'(o_tdata),  32'd0);
    chk("rst2_o_tlast",  32'(o_tlast),  32'd0);
    chk("rst2_o_tuser",  32'(o_tuser),  32'd0);
    chk("rst2_i_tready", 32'(i_tready), 32'd0);
    sb_q.delete();
    exp_ovalid = 1'b0;
    reset_n    = 1'b1;
    set_req(1, 16'h0000, 16'h0000, 1'b0, 1'b0);
    cyc(0);
    cyc(3);
    drop_all();
    cyc(-1);
    cyc(-1);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
